// File: rtl/mac_operand_sequencer_pkg.sv
// Shared types and default sizing for the MAC operand sequencer and its FIFO.
package mac_operand_sequencer_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_LENW     = 4;
  localparam int RESULT_WIDTH = 2 * DEF_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seqState_t;

endpackage

// File: rtl/mac_operand_sequencer_fifo.sv
// Synchronous FIFO holding operand pairs packed as {first, second}.
module operand_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clockPulse,
  input  logic               Reset,
  input  logic               push,
  input  logic               pop,
  input  logic [2*WIDTH-1:0] pushData,
  output logic               full,
  output logic               empty,
  output logic [2*WIDTH-1:0] head
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [PTRW:0]   FULL_COUNT = (PTRW + 1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_ONE    = (PTRW + 1)'(1);
  localparam logic [PTRW-1:0] PTR_ONE    = PTRW'(1);

  logic [2*WIDTH-1:0] mem_r [DEPTH];
  logic [PTRW-1:0]    wrPtr_r;
  logic [PTRW-1:0]    rdPtr_r;
  logic [PTRW:0]      count_r;
  logic               doPush_s;
  logic               doPop_s;

  assign doPush_s = push && !full;
  assign doPop_s  = pop && !empty;
  assign full     = (count_r == FULL_COUNT);
  assign empty    = (count_r == {(PTRW + 1){1'b0}});
  assign head     = mem_r[rdPtr_r];

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clockPulse) begin
    if (!Reset) begin
      wrPtr_r <= {PTRW{1'b0}};
      rdPtr_r <= {PTRW{1'b0}};
      count_r <= {(PTRW + 1){1'b0}};
    end else begin
      if (doPush_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge clockPulse) begin
    if (doPush_s) begin
      mem_r[wrPtr_r] <= pushData;
    end
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds buffered operand pairs to the MAC stage, one dot-product job per start,
// with zero operands whenever no pair is being issued.
module mac_operand_sequencer
  import mac_operand_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LENW  = DEF_LENW
) (
  input  logic             clockPulse,
  input  logic             Reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inOne,
  input  logic [WIDTH-1:0] inTwo,
  input  logic             start,
  input  logic [LENW-1:0]  vecLen,
  output logic             busy,
  output logic [WIDTH-1:0] numberOne,
  output logic [WIDTH-1:0] numberTwo,
  output logic             macClear,
  output logic             done
);

  localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

  seqState_t          state_r;
  seqState_t          stateNext_s;
  logic [LENW-1:0]    remaining_r;
  logic [LENW-1:0]    remainingNext_s;
  logic [WIDTH-1:0]   opOne_r;
  logic [WIDTH-1:0]   opTwo_r;
  logic [WIDTH-1:0]   opOneNext_s;
  logic [WIDTH-1:0]   opTwoNext_s;
  logic               busy_r;
  logic               done_r;
  logic               clear_r;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [2*WIDTH-1:0] head_s;

  operand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clockPulse (clockPulse),
    .Reset      (Reset),
    .push       (inValid && inReady),
    .pop        (pop_s),
    .pushData   ({inOne, inTwo}),
    .full       (full_s),
    .empty      (empty_s),
    .head       (head_s)
  );

  // Next-state, remaining count and operand selection.
  always_comb begin
    stateNext_s     = state_r;
    remainingNext_s = remaining_r;
    opOneNext_s     = {WIDTH{1'b0}};
    opTwoNext_s     = {WIDTH{1'b0}};
    pop_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          stateNext_s     = CLEAR;
          remainingNext_s = vecLen;
        end else begin
          stateNext_s = IDLE;
        end
      end
      CLEAR: begin
        if (remaining_r != {LENW{1'b0}}) begin
          stateNext_s = RUN;
        end else begin
          stateNext_s = DONE;
        end
      end
      RUN: begin
        // An empty FIFO leaves the zero defaults in place as a bubble.
        if (!empty_s) begin
          pop_s           = 1'b1;
          opOneNext_s     = head_s[2*WIDTH-1:WIDTH];
          opTwoNext_s     = head_s[WIDTH-1:0];
          remainingNext_s = remaining_r - LEN_ONE;
          if (remaining_r == LEN_ONE) begin
            stateNext_s = DRAIN;
          end else begin
            stateNext_s = RUN;
          end
        end else begin
          stateNext_s = RUN;
        end
      end
      DRAIN:   stateNext_s = DONE;
      DONE:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // State, counter, operand and status flag registers.
  always_ff @(posedge clockPulse) begin
    if (!Reset) begin
      state_r     <= IDLE;
      remaining_r <= {LENW{1'b0}};
      opOne_r     <= {WIDTH{1'b0}};
      opTwo_r     <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      clear_r     <= 1'b0;
    end else begin
      state_r     <= stateNext_s;
      remaining_r <= remainingNext_s;
      opOne_r     <= opOneNext_s;
      opTwo_r     <= opTwoNext_s;
      busy_r      <= (stateNext_s != IDLE);
      done_r      <= (stateNext_s == DONE);
      clear_r     <= (stateNext_s == CLEAR);
    end
  end

  // Reset forces safe values immediately, not only after the sampling edge.
  assign inReady   = Reset && !full_s;
  assign busy      = Reset && busy_r;
  assign done      = Reset && done_r;
  assign macClear  = !Reset || clear_r;
  assign numberOne = Reset ? opOne_r : {WIDTH{1'b0}};
  assign numberTwo = Reset ? opTwo_r : {WIDTH{1'b0}};

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a behavioural accumulator stage.
module tb_mac_operand_sequencer;
  import mac_operand_sequencer_pkg::*;

  logic       clockPulse = 1'b0;
  logic       Reset;
  logic       inValid;
  logic       inReady;
  logic [7:0] inOne;
  logic [7:0] inTwo;
  logic       start;
  logic [3:0] vecLen;
  logic       busy;
  logic [7:0] numberOne;
  logic [7:0] numberTwo;
  logic       macClear;
  logic       done;

  logic [RESULT_WIDTH-1:0] result;
  int compareCount  = 0;
  int mismatchCount = 0;

  mac_operand_sequencer dut (
    .clockPulse (clockPulse),
    .Reset      (Reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .inOne      (inOne),
    .inTwo      (inTwo),
    .start      (start),
    .vecLen     (vecLen),
    .busy       (busy),
    .numberOne  (numberOne),
    .numberTwo  (numberTwo),
    .macClear   (macClear),
    .done       (done)
  );

  always #5 clockPulse = ~clockPulse;

  // Downstream accumulator: clears on macClear, otherwise adds a product every edge.
  always @(posedge clockPulse) begin
    if (macClear) begin
      result <= 16'd0;
    end else begin
      result <= result + ({8'd0, numberOne} * {8'd0, numberTwo});
    end
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    compareCount++;
    if (got !== want) begin
      mismatchCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic pushPair(input logic [7:0] a, input logic [7:0] b);
    inValid = 1'b1;
    inOne   = a;
    inTwo   = b;
    @(negedge clockPulse);
    inValid = 1'b0;
  endtask

  // Called at the negedge of cycle c0; waits for done and checks its cycle and the sum.
  task automatic waitDone(input int c0, input int expCycle, input logic [15:0] expResult,
                          input string tag);
    int  c;
    logic seen;
    c    = c0;
    seen = 1'b0;
    while (!seen && c < 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        @(negedge clockPulse);
        c++;
      end
    end
    checkValue({tag, "-doneCycle"}, seen ? 32'(c) : 32'd0, 32'(expCycle));
    checkValue({tag, "-result"}, 32'(result), 32'(expResult));
  endtask

  task automatic runJob(input logic [3:0] len, input int expCycle, input logic [15:0] expResult,
                        input string tag);
    start  = 1'b1;
    vecLen = len;
    @(negedge clockPulse);
    start = 1'b0;
    checkValue({tag, "-clear"}, 32'(macClear), 32'd1);
    checkValue({tag, "-busy"}, 32'(busy), 32'd1);
    waitDone(1, expCycle, expResult, tag);
  endtask

  initial begin
    Reset   = 1'b0;
    inValid = 1'b0;
    inOne   = 8'd0;
    inTwo   = 8'd0;
    start   = 1'b0;
    vecLen  = 4'd0;
    @(negedge clockPulse);
    @(negedge clockPulse);
    checkValue("rstMacClear", 32'(macClear), 32'd1);
    checkValue("rstInReady", 32'(inReady), 32'd0);
    checkValue("rstBusy", 32'(busy), 32'd0);
    checkValue("rstDone", 32'(done), 32'd0);
    checkValue("rstOps", 32'({numberOne, numberTwo}), 32'd0);
    Reset = 1'b1;
    @(negedge clockPulse);
    checkValue("postRstMacClear", 32'(macClear), 32'd0);
    checkValue("postRstInReady", 32'(inReady), 32'd1);

    // Basic three-pair job: 6 + 45 + 0.
    pushPair(8'd2, 8'd3);
    pushPair(8'd5, 8'd9);
    pushPair(8'd5, 8'd0);
    runJob(4'd3, 6, 16'd51, "job3");
    @(negedge clockPulse);

    // Silent 16-bit wrap: 4 * 65025 mod 65536.
    for (int i = 0; i < 4; i++) pushPair(8'd255, 8'd255);
    runJob(4'd4, 7, 16'd63492, "wrap");
    @(negedge clockPulse);

    // Full FIFO back-pressure while a fifth pair is held on the input.
    inValid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      inOne = 8'(i);
      inTwo = 8'(i);
      @(negedge clockPulse);
    end
    checkValue("fullReady", 32'(inReady), 32'd0);
    inOne  = 8'd9;
    inTwo  = 8'd9;
    start  = 1'b1;
    vecLen = 4'd4;
    @(negedge clockPulse);
    start = 1'b0;
    checkValue("fullReadyC1", 32'(inReady), 32'd0);
    @(negedge clockPulse);
    checkValue("fullReadyC2", 32'(inReady), 32'd0);
    @(negedge clockPulse);
    checkValue("readyAfterPop", 32'(inReady), 32'd1);
    inValid = 1'b0;
    waitDone(3, 7, 16'd30, "full");
    @(negedge clockPulse);

    // Starved job: bubbles in cycles 2, 3 and 5 push done from 5 to 8; 16 + 7.
    start  = 1'b1;
    vecLen = 4'd2;
    @(negedge clockPulse);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      case (c)
        3: begin inValid = 1'b1; inOne = 8'd4; inTwo = 8'd4; end
        5: begin inValid = 1'b1; inOne = 8'd1; inTwo = 8'd7; end
        default: inValid = 1'b0;
      endcase
      if (c == 4) checkValue("bubbleOps4", 32'({numberOne, numberTwo}), 32'h0000);
      if (c == 5) checkValue("bubbleOps5", 32'({numberOne, numberTwo}), 32'h0404);
      if (c == 6) checkValue("bubbleOps6", 32'({numberOne, numberTwo}), 32'h0000);
      if (c == 7) checkValue("bubbleOps7", 32'({numberOne, numberTwo}), 32'h0107);
      checkValue($sformatf("bubbleDone%0d", c), 32'(done), 32'(c == 8));
      if (c < 8) @(negedge clockPulse);
    end
    checkValue("bubbleResult", 32'(result), 32'd23);
    @(negedge clockPulse);

    // One-cycle reset in the middle of RUN with a pair still queued.
    pushPair(8'd1, 8'd2);
    pushPair(8'd3, 8'd4);
    start  = 1'b1;
    vecLen = 4'd2;
    @(negedge clockPulse);
    start = 1'b0;
    @(negedge clockPulse);
    @(negedge clockPulse);
    Reset = 1'b0;
    #1;
    checkValue("midRstMacClear", 32'(macClear), 32'd1);
    checkValue("midRstBusy", 32'(busy), 32'd0);
    checkValue("midRstInReady", 32'(inReady), 32'd0);
    checkValue("midRstOps", 32'({numberOne, numberTwo}), 32'd0);
    @(negedge clockPulse);
    Reset = 1'b1;
    #1;
    checkValue("afterRstBusy", 32'(busy), 32'd0);
    checkValue("afterRstInReady", 32'(inReady), 32'd1);
    checkValue("afterRstMacClear", 32'(macClear), 32'd0);
    @(negedge clockPulse);
    pushPair(8'd6, 8'd7);
    runJob(4'd1, 4, 16'd42, "postRst");
    @(negedge clockPulse);

    // Zero-length job, with a second start offered while busy.
    start  = 1'b1;
    vecLen = 4'd0;
    @(negedge clockPulse);
    checkValue("zeroClear", 32'(macClear), 32'd1);
    vecLen = 4'd5;
    @(negedge clockPulse);
    start = 1'b0;
    checkValue("zeroDone", 32'(done), 32'd1);
    checkValue("zeroResult", 32'(result), 32'd0);
    @(negedge clockPulse);
    checkValue("ignoredStartC3", 32'(busy), 32'd0);
    @(negedge clockPulse);
    checkValue("ignoredStartC4", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/mac_operand_sequencer.md
# mac_operand_sequencer

Upstream feeder for the multiply-accumulate register stage. It buffers incoming 8-bit operand pairs in a small FIFO and runs one dot-product job per `start`: it clears the accumulator, issues exactly `vecLen` pairs, and drives zero operands whenever it is idle or starved, since the accumulator adds a product on every edge. It pulses `done` in the first cycle in which the stage's 16-bit `Result` holds the complete sum.

## Interface
Parameters:
- `WIDTH`, 8: operand width.
- `DEPTH`, 4: FIFO depth; must be a power of two, at least 2.
- `LENW`, 4: width of `vecLen`; supports jobs of up to 15 pairs.

Ports:
- `clockPulse`  in  1  the single clock. Everything is sampled on the rising edge.
- `Reset`  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `inValid`  in  1  an operand pair is offered on `inOne`/`inTwo`.
- `inReady`  out  1  the FIFO can accept a pair; equal to `!full`.
- `inOne`, `inTwo`  in  WIDTH  operand pair being offered.
- `start`  in  1  begin a job; honoured only in IDLE.
- `vecLen`  in  LENW  number of pairs in the job; sampled together with `start`.
- `busy`  out  1  high in every state except IDLE.
- `numberOne`, `numberTwo`  out  WIDTH  registered operands to the accumulator stage.
- `macClear`  out  1  active-high clear to the accumulator stage; it clears on the edge.
- `done`  out  1  single-cycle pulse; the accumulator `Result` is final in this cycle.

## Operation
- A push happens on any edge where `inValid && inReady`. Pushes are accepted in every state, including IDLE, so the FIFO can be prefilled. Order is preserved.
- State machine, with reset in IDLE:
  - IDLE: operands are 0 and `macClear` is 0. On `start`, latch `vecLen` into `remaining` and go to CLEAR.
  - CLEAR: one cycle with `macClear`=1 and operands 0. Go to RUN if `remaining`≠0, otherwise go to DONE.
  - RUN: on each edge, if the FIFO is non-empty, load the head into the operand registers, pop it, and decrement `remaining`. If the FIFO is empty, load 0 into both operand registers (a starvation bubble). When `remaining` reaches 0 as a result of a pop, go to DRAIN.
  - DRAIN: one cycle with the last pair on the bus. On the exit edge the operand registers load 0. Go to DONE.
  - DONE: one cycle with `done`=1 and operands 0. Return to IDLE.
- Arithmetic is performed by the accumulator stage. It sums `vecLen` products modulo 2^16, so wrap-around is silent and is not flagged.
- Pairs left over in the FIFO after `done` remain queued for the next job.
- `start` is ignored while `busy` is high.
- A push and a pop in the same edge are legal when the FIFO is neither full nor empty. Occupancy is unchanged.
- Reset mid-operation: while `Reset`=0, the following hold:
  - the state returns to IDLE;
  - the FIFO is emptied;
  - `remaining` is set to 0;
  - operands are 0, and `done`, `busy` and `inReady` are 0;
  - `macClear` is 1, so the accumulator is cleared along with the sequencer.

## Timing
- Reset values: `numberOne`=`numberTwo`=0, `done`=0, `busy`=0, `macClear`=1 while in reset and 0 afterwards. `inReady`=0 while in reset and 1 on the first cycle after reset.
- Job latency, with `start` sampled at edge E0 and the FIFO holding at least N pairs:
  - cycle 1 is CLEAR;
  - cycles 2 to N+1 are RUN;
  - cycle N+2 is DRAIN;
  - cycle N+3 is DONE.
  - Each starvation bubble adds one RUN cycle.
- A pair popped at the end of cycle k is on `numberOne`/`numberTwo` during cycle k+1. The accumulator captures it at the end of cycle k+1.
- `inReady` is combinational from the FIFO count and does not depend on `inValid`.

## Structure
- A shared package holds:
  - the state enum (IDLE, CLEAR, RUN, DRAIN, DONE);
  - the default values of WIDTH, DEPTH and LENW;
  - the `Result` width constant, 2×WIDTH.
- One sub-module, `operand_fifo`:
  - synchronous, parameterised by width and depth;
  - stores 2×WIDTH-bit entries;
  - has push/pop inputs and full/empty/head outputs;
  - shares the same synchronous active-low `Reset`.
- The top level contains the FSM, the `remaining` counter and the operand registers.

## Test plan
- Push (2,3), (5,9), (5,0), then `start` with `vecLen`=3. Expected: `macClear` high in cycle 1, `done` in cycle 6, `Result`=51.
- Push four pairs of (255,255), then `start` with `vecLen`=4. Expected: `Result`=63492 (260100 mod 65536) when `done` fires.
- Fill the FIFO with 4 pairs and hold `inValid`=1. Expected: `inReady`=0, the fifth pair is not accepted, and `inReady` returns high on the cycle after the first pop.
- `start` with `vecLen`=2 and the FIFO empty; push (4,4) after 3 cycles and (1,7) after 2 more. Expected: zero operands during the gaps, `done` delayed by exactly the bubble count, `Result`=23.
- Drive `Reset`=0 for one cycle mid-RUN. Expected: IDLE, FIFO empty, `macClear`=1 during reset. A following job with `vecLen`=1 and pair (6,7) gives `Result`=42.
- `start` with `vecLen`=0. Expected: CLEAR then DONE, `Result`=0. A second `start` pulsed while `busy` is high is ignored.
